// File: rtl/mesm6_pic_pkg.sv
// Shared constants for the MESM-6 priority interrupt controller:
// register addresses, the "no vector" code and the bus FSM states.
package mesm6_pic_pkg;

    localparam logic [3:0] A_VEC    = 4'o00;
    localparam logic [3:0] A_ACK    = 4'o01;
    localparam logic [3:0] A_IECCLR = 4'o02;
    localparam logic [3:0] A_IECSET = 4'o03;
    localparam logic [3:0] A_IEC    = 4'o04;
    localparam logic [3:0] A_IFSCLR = 4'o05;
    localparam logic [3:0] A_IFSSET = 4'o06;
    localparam logic [3:0] A_IFS    = 4'o07;
    localparam logic [3:0] A_IMODE  = 4'o10;
    localparam logic [3:0] A_CTRL   = 4'o11;

    localparam logic [5:0] NONE = 6'o77;

    typedef enum logic {
        S_IDLE,
        S_DONE
    } state_e;

endpackage

// File: rtl/mesm6_pic_if.sv
// Register bus between the CPU and the interrupt controller.
// The CPU side is the master; the controller is the slave.
interface mesm6_pic_if;

    logic [14:0] pic_addr;
    logic        pic_read;
    logic        pic_write;
    logic [47:0] pic_wdata;
    logic [47:0] pic_rdata;
    logic        pic_done;

    modport master (
        output pic_addr, pic_read, pic_write, pic_wdata,
        input  pic_rdata, pic_done
    );

    modport slave (
        input  pic_addr, pic_read, pic_write, pic_wdata,
        output pic_rdata, pic_done
    );

endinterface

// File: rtl/mesm6_prio_enc.sv
// Combinational priority encoder: index of the lowest set request bit,
// or NONE when no request is pending.
module mesm6_prio_enc
    import mesm6_pic_pkg::*;
#(
    parameter int W = 48
) (
    input  logic [W-1:0] req_i,
    output logic [5:0]   idx_o,
    output logic         valid_o
);

    // Scanning downward lets the lowest index overwrite higher ones.
    always_comb begin
        idx_o   = NONE;
        valid_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = 6'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesm6_pic_prio.sv
// MESM-6 priority interrupt controller: per-line edge/level capture,
// enable mask, lowest-index-first vectoring and a done-handshake bus.
module mesm6_pic_prio
    import mesm6_pic_pkg::*;
#(
    parameter int              NIRQ       = 48,
    parameter logic [NIRQ-1:0] EDGE_RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            interrupt,
    input  logic [NIRQ-1:0] dev_irq,
    mesm6_pic_if.slave      bus
);

    state_e          state_q;
    logic            done_q;
    logic            int_q;
    logic [47:0]     rdata_q, rdata_d;
    logic [NIRQ-1:0] dev_q;
    logic [NIRQ-1:0] ifs_q, ifs_d;
    logic [NIRQ-1:0] iec_q, iec_d;
    logic [NIRQ-1:0] imode_q, imode_d;
    logic            gie_q, gie_d;

    logic [NIRQ-1:0] wd, hw_set, pend, ack_mask;
    logic [3:0]      addr;
    logic [5:0]      vec;
    logic            vec_vld;
    logic            acc, wr_acc, rd_acc;
    logic            unused_ok;

    assign unused_ok = ^{bus.pic_addr[14:4], bus.pic_wdata};

    assign addr   = bus.pic_addr[3:0];
    assign wd     = bus.pic_wdata[NIRQ-1:0];
    assign acc    = (state_q == S_IDLE) && (bus.pic_read || bus.pic_write);
    assign wr_acc = acc && bus.pic_write;
    assign rd_acc = acc && bus.pic_read && !bus.pic_write;

    // Edge lines fire on a rising input, level lines whenever sampled high.
    assign hw_set   = (imode_q & dev_irq & ~dev_q) | (~imode_q & dev_q);
    assign pend     = ifs_q & iec_q;
    assign ack_mask = NIRQ'(1) << vec;

    mesm6_prio_enc #(
        .W (NIRQ)
    ) u_enc (
        .req_i   (pend),
        .idx_o   (vec),
        .valid_o (vec_vld)
    );

    always_comb begin
        ifs_d   = ifs_q;
        iec_d   = iec_q;
        imode_d = imode_q;
        gie_d   = gie_q;
        if (wr_acc) begin
            case (addr)
                A_IECCLR: iec_d   = iec_q & ~wd;
                A_IECSET: iec_d   = iec_q | wd;
                A_IEC:    iec_d   = wd;
                A_IFSCLR: ifs_d   = ifs_q & ~wd;
                A_IFSSET: ifs_d   = ifs_q | wd;
                A_IFS:    ifs_d   = wd;
                A_IMODE:  imode_d = wd;
                A_CTRL:   gie_d   = bus.pic_wdata[0];
                default:  ;
            endcase
        end
        if (rd_acc && addr == A_ACK && vec_vld) begin
            ifs_d = ifs_q & ~ack_mask;
        end
        // Hardware requests override any software clear or load.
        ifs_d = ifs_d | hw_set;
    end

    always_comb begin
        rdata_d = '0;
        case (addr)
            A_VEC, A_ACK:              rdata_d = 48'(vec);
            A_IECCLR, A_IECSET, A_IEC: rdata_d = 48'(iec_q);
            A_IFSCLR, A_IFSSET, A_IFS: rdata_d = 48'(ifs_q);
            A_IMODE:                   rdata_d = 48'(imode_q);
            A_CTRL:                    rdata_d = {47'b0, gie_q};
            default:                   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            int_q   <= 1'b0;
            rdata_q <= '0;
            dev_q   <= '0;
            ifs_q   <= '0;
            iec_q   <= '0;
            imode_q <= EDGE_RESET;
            gie_q   <= 1'b1;
        end else begin
            dev_q   <= dev_irq;
            ifs_q   <= ifs_d;
            iec_q   <= iec_d;
            imode_q <= imode_d;
            gie_q   <= gie_d;
            int_q   <= gie_q & (|pend);
            case (state_q)
                S_IDLE: begin
                    if (acc) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        rdata_q <= rdata_d;
                    end
                end
                S_DONE: begin
                    if (!bus.pic_read && !bus.pic_write) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt     = int_q;
    assign bus.pic_done  = done_q;
    assign bus.pic_rdata = rdata_q;

endmodule

// File: tb/tb_mesm6_pic_prio.sv
// Directed bench for mesm6_pic_prio with a read-data scoreboard;
// a 48-line and an 8-line controller are exercised side by side.
module tb_mesm6_pic_prio;
    import mesm6_pic_pkg::*;

    typedef struct {
        int          tag;
        logic [47:0] val;
        logic        chk;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        int48, int8;
    logic [47:0] dev48;
    logic [7:0]  dev8;

    int checks;
    int failures;

    exp_t q48[$];
    exp_t q8[$];
    logic d48_prev, d8_prev;

    mesm6_pic_if b48 ();
    mesm6_pic_if b8 ();

    mesm6_pic_prio #(.NIRQ(48)) u48 (
        .clk       (clk),
        .reset     (reset),
        .interrupt (int48),
        .dev_irq   (dev48),
        .bus       (b48)
    );

    mesm6_pic_prio #(.NIRQ(8)) u8 (
        .clk       (clk),
        .reset     (reset),
        .interrupt (int8),
        .dev_irq   (dev8),
        .bus       (b8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] got,
                       input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: one entry per rising pic_done.
    always @(negedge clk) begin
        exp_t e;
        if (b48.pic_done === 1'b1 && d48_prev !== 1'b1) begin
            if (q48.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done48");
            end else begin
                e = q48.pop_front();
                if (e.chk) begin
                    checks++;
                    if (b48.pic_rdata !== e.val) begin
                        failures++;
                        $display("FAIL rd48_tag%0d got=%0h exp=%0h",
                                 e.tag, b48.pic_rdata, e.val);
                    end
                end
            end
        end
        if (b8.pic_done === 1'b1 && d8_prev !== 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done8");
            end else begin
                e = q8.pop_front();
                if (e.chk) begin
                    checks++;
                    if (b8.pic_rdata !== e.val) begin
                        failures++;
                        $display("FAIL rd8_tag%0d got=%0h exp=%0h",
                                 e.tag, b8.pic_rdata, e.val);
                    end
                end
            end
        end
        d48_prev = b48.pic_done;
        d8_prev  = b8.pic_done;
    end

    task automatic drv(input bit s8, input logic [3:0] a, input bit rd,
                       input bit wr, input logic [47:0] wd);
        if (s8) begin
            b8.pic_addr  = {11'b0, a};
            b8.pic_read  = rd;
            b8.pic_write = wr;
            b8.pic_wdata = wd;
        end else begin
            b48.pic_addr  = {11'b0, a};
            b48.pic_read  = rd;
            b48.pic_write = wr;
            b48.pic_wdata = wd;
        end
    endtask

    function automatic logic dn(input bit s8);
        return s8 ? b8.pic_done : b48.pic_done;
    endfunction

    task automatic wait_dn(input bit s8, input logic v);
        int n = 0;
        while (dn(s8) !== v && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("done_timeout", {47'b0, dn(s8)}, {47'b0, v});
    endtask

    task automatic acc(input bit s8, input logic [3:0] a, input bit rd,
                       input bit wr, input logic [47:0] wd, input int hold,
                       input bit c, input logic [47:0] ex, input int tag);
        exp_t e;
        e.tag = tag;
        e.val = ex;
        e.chk = c;
        if (s8) q8.push_back(e);
        else q48.push_back(e);
        @(negedge clk);
        drv(s8, a, rd, wr, wd);
        wait_dn(s8, 1'b1);
        repeat (hold) @(negedge clk);
        drv(s8, a, 1'b0, 1'b0, wd);
        wait_dn(s8, 1'b0);
    endtask

    task automatic wr(input bit s8, input logic [3:0] a,
                      input logic [47:0] wd);
        acc(s8, a, 1'b0, 1'b1, wd, 0, 1'b0, '0, 0);
    endtask

    task automatic rd(input bit s8, input logic [3:0] a,
                      input logic [47:0] ex, input int tag);
        acc(s8, a, 1'b1, 1'b0, '0, 0, 1'b1, ex, tag);
    endtask

    localparam logic [47:0] ALL1 = {48{1'b1}};

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        d48_prev = 1'b0;
        d8_prev  = 1'b0;
        clk      = 1'b0;
        reset    = 1'b1;
        dev48    = '0;
        dev8     = '0;
        drv(1'b0, 4'd0, 1'b0, 1'b0, '0);
        drv(1'b1, 4'd0, 1'b0, 1'b0, '0);

        repeat (3) @(negedge clk);
        chk("rst_int48", {47'b0, int48}, 48'd0);
        chk("rst_done48", {47'b0, b48.pic_done}, 48'd0);
        chk("rst_rdata48", b48.pic_rdata, 48'd0);
        chk("rst_int8", {47'b0, int8}, 48'd0);
        reset = 1'b0;

        rd(0, A_IFS, 48'd0, 1);
        rd(0, A_IEC, 48'd0, 2);
        rd(0, A_IMODE, 48'd0, 3);
        rd(0, A_CTRL, 48'd1, 4);
        rd(0, A_VEC, 48'o77, 5);

        // Level line 9
        @(negedge clk);
        dev48[9] = 1'b1;
        repeat (2) @(negedge clk);
        wr(0, A_IEC, 48'd1 << 9);
        chk("lvl_int_on", {47'b0, int48}, 48'd1);
        rd(0, A_VEC, 48'd9, 6);
        wr(0, A_IFSCLR, 48'd1 << 9);
        rd(0, A_IFS, 48'd1 << 9, 7);
        dev48[9] = 1'b0;
        wr(0, A_IFSCLR, 48'd1 << 9);
        rd(0, A_IFS, 48'd0, 8);
        chk("lvl_int_off", {47'b0, int48}, 48'd0);
        wr(0, A_IEC, 48'd0);

        // Edge line 19
        wr(0, A_IMODE, 48'd1 << 19);
        @(negedge clk);
        dev48[19] = 1'b1;
        @(negedge clk);
        dev48[19] = 1'b0;
        wr(0, A_IECSET, 48'd1 << 19);
        chk("edge_int_on", {47'b0, int48}, 48'd1);
        rd(0, A_ACK, 48'd19, 10);
        rd(0, A_IFS, 48'd0, 11);
        chk("edge_int_off", {47'b0, int48}, 48'd0);

        // Priority
        wr(0, A_IFSSET, 48'o1000004);
        wr(0, A_IEC, ALL1);
        rd(0, A_VEC, 48'd2, 12);
        rd(0, A_ACK, 48'd2, 13);
        rd(0, A_VEC, 48'd18, 14);
        rd(0, A_ACK, 48'd18, 15);
        rd(0, A_VEC, 48'o77, 16);
        rd(0, A_ACK, 48'o77, 17);
        rd(0, A_IFS, 48'd0, 18);

        // Global enable
        wr(0, A_IFSSET, 48'd1 << 5);
        chk("gie_pend", {47'b0, int48}, 48'd1);
        wr(0, A_CTRL, 48'd0);
        chk("gie_off", {47'b0, int48}, 48'd0);
        rd(0, A_CTRL, 48'd0, 19);
        wr(0, A_CTRL, 48'd1);
        chk("gie_on", {47'b0, int48}, 48'd1);
        wr(0, A_IFSCLR, ALL1);

        // Both strobes high acts as a write
        acc(0, A_IFSSET, 1'b1, 1'b1, 48'd1 << 7, 0, 1'b0, '0, 0);
        rd(0, A_IFS, 48'd1 << 7, 20);
        wr(0, A_IFSCLR, ALL1);

        // Write strobe held for five cycles
        e.tag = 0;
        e.val = '0;
        e.chk = 1'b0;
        q48.push_back(e);
        @(negedge clk);
        drv(0, A_IFSSET, 1'b0, 1'b1, 48'h18);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("hs_done_c%0d", k), {47'b0, b48.pic_done}, 48'd1);
        end
        drv(0, A_IFSSET, 1'b0, 1'b0, 48'h18);
        @(negedge clk);
        chk("hs_drop", {47'b0, b48.pic_done}, 48'd0);
        acc(0, A_ACK, 1'b1, 1'b0, '0, 2, 1'b1, 48'd3, 30);
        rd(0, A_IFS, 48'h10, 31);

        // Reset in the middle of an access, strobe held through it
        e.tag = 40;
        e.val = 48'd4;
        e.chk = 1'b1;
        q48.push_back(e);
        e.tag = 41;
        e.val = 48'o77;
        q48.push_back(e);
        @(negedge clk);
        drv(0, A_VEC, 1'b1, 1'b0, '0);
        wait_dn(0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_done", {47'b0, b48.pic_done}, 48'd0);
        chk("rstmid_rdata", b48.pic_rdata, 48'd0);
        chk("rstmid_int", {47'b0, int48}, 48'd0);
        reset = 1'b0;
        wait_dn(0, 1'b1);
        drv(0, A_VEC, 1'b0, 1'b0, '0);
        wait_dn(0, 1'b0);
        rd(0, A_IFS, 48'd0, 42);
        rd(0, A_IEC, 48'd0, 43);
        rd(0, A_IMODE, 48'd0, 44);
        rd(0, A_CTRL, 48'd1, 45);
        rd(0, 4'o12, 48'd0, 46);

        // Eight-line build
        wr(1, A_IEC, 48'hFFFF_FFFF_FF01);
        rd(1, A_IEC, 48'd1, 50);
        wr(1, A_IFSSET, 48'h0000_0000_0F00);
        rd(1, A_IFS, 48'd0, 51);
        rd(1, A_VEC, 48'o77, 52);
        wr(1, 4'o15, 48'hFF);
        rd(1, 4'o15, 48'd0, 53);
        @(negedge clk);
        dev8[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("n8_int", {47'b0, int8}, 48'd1);
        rd(1, A_VEC, 48'd0, 54);

        repeat (5) @(negedge clk);
        chk("sb_drain", 48'(q48.size() + q8.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
